// File: rtl/pipe_ctrl_regs.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_regs
//
// Pipeline control registers for a classic five-stage in-order core:
//   * the program counter, with a write-enable used for stalls,
//   * the IF/ID register (instruction, PC+4, valid), with hold and flush,
//   * the control-bit shift chain ID/EX -> EX/MEM -> MEM/WB, where each
//     stage can be forced to a bubble (all-zero control),
//   * two saturating 16-bit event counters (stall cycles, flush cycles).
//
// Ports
//   clk_i                 single clock, all state updates on the rising edge
//   rst_i                 synchronous, active-high reset
//   PCWrite_i             1 = PC loads PC_next_i, 0 = PC holds (stall)
//   WritePipeReg_IFID_i   1 = IF/ID loads, 0 = IF/ID holds
//   Flush_IFID_i          1 = IF/ID becomes a bubble (wins over the write)
//   ControlReset_ID_i     1 = zero the control entering ID/EX
//   ControlReset_EX_i     1 = zero the control entering EX/MEM
//   ControlReset_MEM_i    1 = zero the control entering MEM/WB
//   PC_next_i             next PC from the PC-source mux
//   Instr_IF_i            fetched instruction
//   PCplus4_IF_i          PC+4 of the fetched instruction
//   Ctrl_ID_i             decoded control: [9:5] EX, [4:2] MEM, [1:0] WB
//   PC_o                  current PC
//   Instr_IFID_o          IF/ID instruction
//   PCplus4_IFID_o        IF/ID PC+4
//   Valid_IFID_o          IF/ID holds a real instruction
//   Ctrl_IDEX_o           ID/EX control (all fields)
//   Ctrl_EXMEM_o          EX/MEM control (MEM + WB fields)
//   Ctrl_MEMWB_o          MEM/WB control (WB field)
//   StallCount_o          edges with PCWrite_i = 0, saturating
//   FlushCount_o          edges with Flush_IFID_i = 1, saturating
// -----------------------------------------------------------------------------
module pipe_ctrl_regs (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PCWrite_i,
  input  logic        WritePipeReg_IFID_i,
  input  logic        Flush_IFID_i,
  input  logic        ControlReset_ID_i,
  input  logic        ControlReset_EX_i,
  input  logic        ControlReset_MEM_i,
  input  logic [31:0] PC_next_i,
  input  logic [31:0] Instr_IF_i,
  input  logic [31:0] PCplus4_IF_i,
  input  logic [9:0]  Ctrl_ID_i,
  output logic [31:0] PC_o,
  output logic [31:0] Instr_IFID_o,
  output logic [31:0] PCplus4_IFID_o,
  output logic        Valid_IFID_o,
  output logic [9:0]  Ctrl_IDEX_o,
  output logic [4:0]  Ctrl_EXMEM_o,
  output logic [1:0]  Ctrl_MEMWB_o,
  output logic [15:0] StallCount_o,
  output logic [15:0] FlushCount_o
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // IF/ID contents kept together so hold/flush/load treat them as one unit.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

  logic [31:0] pc_d,         pc_q;
  ifid_t       ifid_d,       ifid_q;
  logic [9:0]  ctrl_idex_d,  ctrl_idex_q;
  logic [4:0]  ctrl_exmem_d, ctrl_exmem_q;
  logic [1:0]  ctrl_memwb_d, ctrl_memwb_q;
  logic [15:0] stall_cnt_d,  stall_cnt_q;
  logic [15:0] flush_cnt_d,  flush_cnt_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a "hold" default before any condition so no
    // path leaves it unassigned; that is what keeps this block latch-free.
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (PCWrite_i) begin
      pc_d = PC_next_i;
    end

    // Flush beats write: a squashed fetch must never reach decode.
    if (Flush_IFID_i) begin
      ifid_d = IFID_BUBBLE;
    end else if (WritePipeReg_IFID_i) begin
      ifid_d = '{instr: Instr_IF_i, pc_plus4: PCplus4_IF_i, valid: 1'b1};
    end

    // The control chain never holds: a stall is expressed as a bubble
    // injected through the per-stage control resets.
    ctrl_idex_d  = ControlReset_ID_i  ? 10'h000 : Ctrl_ID_i;
    ctrl_exmem_d = ControlReset_EX_i  ? 5'h00   : ctrl_idex_q[4:0];
    ctrl_memwb_d = ControlReset_MEM_i ? 2'h0    : ctrl_exmem_q[1:0];

    // Counters stick at all-ones instead of wrapping.
    if (!PCWrite_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (Flush_IFID_i && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, regardless of statement order.
    if (rst_i) begin
      pc_q         <= 32'h0;
      ifid_q       <= IFID_BUBBLE;
      ctrl_idex_q  <= 10'h000;
      ctrl_exmem_q <= 5'h00;
      ctrl_memwb_q <= 2'h0;
      stall_cnt_q  <= 16'h0;
      flush_cnt_q  <= 16'h0;
    end else begin
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      ctrl_idex_q  <= ctrl_idex_d;
      ctrl_exmem_q <= ctrl_exmem_d;
      ctrl_memwb_q <= ctrl_memwb_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from flops
  // ---------------------------------------------------------------------------
  assign PC_o           = pc_q;
  assign Instr_IFID_o   = ifid_q.instr;
  assign PCplus4_IFID_o = ifid_q.pc_plus4;
  assign Valid_IFID_o   = ifid_q.valid;
  assign Ctrl_IDEX_o    = ctrl_idex_q;
  assign Ctrl_EXMEM_o   = ctrl_exmem_q;
  assign Ctrl_MEMWB_o   = ctrl_memwb_q;
  assign StallCount_o   = stall_cnt_q;
  assign FlushCount_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_regs
//
// Self-checking bench for pipe_ctrl_regs. A behavioural model tracks what
// every output should be after each rising edge; directed sequences cover the
// reset, load-use stall, flush, control-chain and counter-saturation cases,
// and a randomized phase exercises all inputs together.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_regs;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        PCWrite_i;
  logic        WritePipeReg_IFID_i;
  logic        Flush_IFID_i;
  logic        ControlReset_ID_i;
  logic        ControlReset_EX_i;
  logic        ControlReset_MEM_i;
  logic [31:0] PC_next_i;
  logic [31:0] Instr_IF_i;
  logic [31:0] PCplus4_IF_i;
  logic [9:0]  Ctrl_ID_i;
  logic [31:0] PC_o;
  logic [31:0] Instr_IFID_o;
  logic [31:0] PCplus4_IFID_o;
  logic        Valid_IFID_o;
  logic [9:0]  Ctrl_IDEX_o;
  logic [4:0]  Ctrl_EXMEM_o;
  logic [1:0]  Ctrl_MEMWB_o;
  logic [15:0] StallCount_o;
  logic [15:0] FlushCount_o;

  pipe_ctrl_regs dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .PCWrite_i           (PCWrite_i),
    .WritePipeReg_IFID_i (WritePipeReg_IFID_i),
    .Flush_IFID_i        (Flush_IFID_i),
    .ControlReset_ID_i   (ControlReset_ID_i),
    .ControlReset_EX_i   (ControlReset_EX_i),
    .ControlReset_MEM_i  (ControlReset_MEM_i),
    .PC_next_i           (PC_next_i),
    .Instr_IF_i          (Instr_IF_i),
    .PCplus4_IF_i        (PCplus4_IF_i),
    .Ctrl_ID_i           (Ctrl_ID_i),
    .PC_o                (PC_o),
    .Instr_IFID_o        (Instr_IFID_o),
    .PCplus4_IFID_o      (PCplus4_IFID_o),
    .Valid_IFID_o        (Valid_IFID_o),
    .Ctrl_IDEX_o         (Ctrl_IDEX_o),
    .Ctrl_EXMEM_o        (Ctrl_EXMEM_o),
    .Ctrl_MEMWB_o        (Ctrl_MEMWB_o),
    .StallCount_o        (StallCount_o),
    .FlushCount_o        (FlushCount_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: architectural view of the pipeline registers.
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [9:0]  m_idex;
  logic [4:0]  m_exmem;
  logic [1:0]  m_memwb;
  int          m_stall, m_flush;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_edge();
    if (rst_i) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_idex = 0; m_exmem = 0; m_memwb = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      // Later stages first so each takes its predecessor's pre-edge value.
      m_memwb = ControlReset_MEM_i ? 2'b0 : m_exmem[1:0];
      m_exmem = ControlReset_EX_i  ? 5'b0 : m_idex[4:0];
      m_idex  = ControlReset_ID_i  ? 10'b0 : Ctrl_ID_i;
      if (PCWrite_i) m_pc = PC_next_i;
      if (Flush_IFID_i) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (WritePipeReg_IFID_i) begin
        m_instr = Instr_IF_i; m_pc4 = PCplus4_IF_i; m_valid = 1;
      end
      if (!PCWrite_i)   m_stall = sat16(m_stall + 1);
      if (Flush_IFID_i) m_flush = sat16(m_flush + 1);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    PC_o,                  m_pc);
    check({tag, ".instr"}, Instr_IFID_o,          m_instr);
    check({tag, ".pc4"},   PCplus4_IFID_o,        m_pc4);
    check({tag, ".valid"}, 32'(Valid_IFID_o),     32'(m_valid));
    check({tag, ".idex"},  32'(Ctrl_IDEX_o),      32'(m_idex));
    check({tag, ".exmem"}, 32'(Ctrl_EXMEM_o),     32'(m_exmem));
    check({tag, ".memwb"}, 32'(Ctrl_MEMWB_o),     32'(m_memwb));
    check({tag, ".stall"}, 32'(StallCount_o),     32'(m_stall));
    check({tag, ".flush"}, 32'(FlushCount_o),     32'(m_flush));
  endtask

  // One rising edge: model follows the inputs seen at the edge, outputs are
  // sampled 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    rst_i = 0; PCWrite_i = 1; WritePipeReg_IFID_i = 0; Flush_IFID_i = 0;
    ControlReset_ID_i = 0; ControlReset_EX_i = 0; ControlReset_MEM_i = 0;
    PC_next_i = 0; Instr_IF_i = 0; PCplus4_IF_i = 0; Ctrl_ID_i = 0;
  endtask

  initial begin
    idle_inputs();

    // Reset, with other inputs active to show rst_i overrides them.
    rst_i = 1; PCWrite_i = 0; Flush_IFID_i = 1; WritePipeReg_IFID_i = 1;
    Ctrl_ID_i = 10'h3FF; PC_next_i = 32'hDEAD_BEEF;
    tick("reset");
    check("reset.pc_zero", PC_o, 32'h0);
    check("reset.valid_zero", 32'(Valid_IFID_o), 32'h0);

    // Basic PC load; IF/ID not yet written.
    idle_inputs();
    PC_next_i = 32'h4; PCWrite_i = 1;
    tick("pc_load");
    check("pc_load.pc4", PC_o, 32'h4);
    check("pc_load.stall0", 32'(StallCount_o), 32'h0);
    check("pc_load.flush0", 32'(FlushCount_o), 32'h0);
    check("pc_load.valid0", 32'(Valid_IFID_o), 32'h0);

    // Load-use: fetch a load, then stall with a bubble into ID/EX.
    Instr_IF_i = 32'h8C22_0000; PCplus4_IF_i = 32'h8; WritePipeReg_IFID_i = 1;
    PC_next_i = 32'h8; Ctrl_ID_i = 10'h155;
    tick("lu_fetch");
    check("lu_fetch.instr", Instr_IFID_o, 32'h8C22_0000);
    PCWrite_i = 0; WritePipeReg_IFID_i = 0; ControlReset_ID_i = 1;
    PC_next_i = 32'hC; Instr_IF_i = 32'h0043_2020; PCplus4_IF_i = 32'hC;
    tick("lu_stall");
    check("lu_stall.pc", PC_o, 32'h8);
    check("lu_stall.instr", Instr_IFID_o, 32'h8C22_0000);
    check("lu_stall.idex", 32'(Ctrl_IDEX_o), 32'h0);
    check("lu_stall.stall1", 32'(StallCount_o), 32'h1);

    // Flush with write deasserted.
    idle_inputs();
    PCWrite_i = 1; PC_next_i = 32'h10; Flush_IFID_i = 1;
    tick("flush");
    check("flush.instr", Instr_IFID_o, 32'h0);
    check("flush.valid", 32'(Valid_IFID_o), 32'h0);
    check("flush.cnt", 32'(FlushCount_o), 32'h1);

    // Flush wins over write.
    Flush_IFID_i = 1; WritePipeReg_IFID_i = 1; Instr_IF_i = 32'h1234_5678;
    tick("flush_wins");
    check("flush_wins.instr", Instr_IFID_o, 32'h0);

    // Control chain: full propagation over three edges.
    idle_inputs();
    Ctrl_ID_i = 10'h3FF;
    for (int i = 0; i < 3; i++) tick("chain");
    check("chain.idex", 32'(Ctrl_IDEX_o), 32'h3FF);
    check("chain.exmem", 32'(Ctrl_EXMEM_o), 32'h1F);
    check("chain.memwb", 32'(Ctrl_MEMWB_o), 32'h3);

    // Drain, then inject 3FF and kill it at EX/MEM on edge 2.
    Ctrl_ID_i = 10'h0;
    for (int i = 0; i < 3; i++) tick("drain");
    Ctrl_ID_i = 10'h3FF;
    tick("exrst_e1");
    ControlReset_EX_i = 1;
    tick("exrst_e2");
    check("exrst_e2.exmem", 32'(Ctrl_EXMEM_o), 32'h0);
    check("exrst_e2.idex", 32'(Ctrl_IDEX_o), 32'h3FF);
    ControlReset_EX_i = 0;
    tick("exrst_e3");
    check("exrst_e3.memwb", 32'(Ctrl_MEMWB_o), 32'h0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rst_i               = ($urandom_range(0, 49) == 0);
      PCWrite_i           = $urandom_range(0, 3) != 0;
      WritePipeReg_IFID_i = $urandom_range(0, 1) != 0;
      Flush_IFID_i        = ($urandom_range(0, 5) == 0);
      ControlReset_ID_i   = ($urandom_range(0, 4) == 0);
      ControlReset_EX_i   = ($urandom_range(0, 4) == 0);
      ControlReset_MEM_i  = ($urandom_range(0, 4) == 0);
      PC_next_i           = $urandom;
      Instr_IF_i          = $urandom;
      PCplus4_IF_i        = $urandom;
      Ctrl_ID_i           = 10'($urandom);
      tick("rand");
    end

    // Stall-counter saturation from zero.
    idle_inputs();
    rst_i = 1;
    tick("sat_reset");
    rst_i = 0; PCWrite_i = 0;
    for (int i = 0; i < 65540; i++) tick("sat");
    check("sat.stall_max", 32'(StallCount_o), 32'hFFFF);

    // Reset in the middle of a stall and flush with nonzero counters.
    Flush_IFID_i = 1; WritePipeReg_IFID_i = 1; Instr_IF_i = 32'hCAFE_F00D;
    Ctrl_ID_i = 10'h2AA;
    for (int i = 0; i < 4; i++) tick("pre_rst");
    rst_i = 1;
    tick("mid_rst");
    check("mid_rst.stall", 32'(StallCount_o), 32'h0);
    check("mid_rst.flush", 32'(FlushCount_o), 32'h0);
    check("mid_rst.idex", 32'(Ctrl_IDEX_o), 32'h0);
    check("mid_rst.pc", PC_o, 32'h0);

    // First edge after reset loads normally.
    idle_inputs();
    WritePipeReg_IFID_i = 1; Instr_IF_i = 32'h0000_0013; PC_next_i = 32'h100;
    tick("post_rst");
    check("post_rst.valid", 32'(Valid_IFID_o), 32'h1);
    check("post_rst.pc", PC_o, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
